// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_pkg
//  Purpose  : Shared definitions for the programmable clock divider:
//             controller state encoding, reset-time ratio defaults and the
//             config validity check used by the handshake logic.
//  Revision : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Ratio loaded into the active registers by reset (33% duty).
    localparam int DIV_DEF_PERIOD = 6;
    localparam int DIV_DEF_HIGH   = 2;

    // Width used by the validity check. Config fields are zero-extended to
    // this width, so the comparisons keep their unsigned CNT_W meaning.
    localparam int CFG_CHK_W = 32;

    // Controller states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } div_state_e;

    // A ratio is usable only if it has at least one high and one low cycle.
    function automatic logic cfg_is_valid(
        input logic [CFG_CHK_W-1:0] period,
        input logic [CFG_CHK_W-1:0] high
    );
        return (period >= 32'd2) && (high >= 32'd1) && (high < period);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_core.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_core
//  Purpose  : Divider datapath. Owns the in-period cycle counter and the
//             registered divided clock. Reports when the counter sits on the
//             last cycle of the current period. Period/high values and the
//             run enable come from the controller.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             active,      // controller is RUN or STOP this cycle
    input  logic             active_nxt,  // controller is RUN or STOP next cycle
    input  logic [CNT_W-1:0] act_period,  // period in force this cycle
    input  logic [CNT_W-1:0] nxt_high,    // high time in force next cycle
    output logic             at_last,     // counter is on the final cycle of the period
    output logic             clk_out
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             clk_out_q;
    logic             clk_out_d;

    // The only arithmetic in the divider; the wrap test reuses the increment
    // so no subtraction from the period is needed.
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign at_last = (cnt_inc == act_period);

    // Next count and next clock level. A fresh start, a wrap and a return to
    // idle all reload zero; clk_out follows the count it will be paired with,
    // using the high time that will be active on that same cycle.
    always_comb begin
        cnt_d = '0;
        if (active_nxt && active && !at_last) begin
            cnt_d = cnt_inc;
        end
        clk_out_d = active_nxt && (cnt_d < nxt_high);
    end

    // Counter and divided-clock registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign clk_out = clk_out_q;

endmodule
`default_nettype wire

// File: rtl/clk_div_sched.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_sched
//  Purpose  : Run-time controller for a programmable integer clock divider.
//             Accepts new period/high ratios over valid/ready, holds them in
//             a one-deep pending slot and applies them only at period
//             boundaries (or immediately when idle), so clk_out never shows
//             runt or stretched pulses. Sequences clean start/stop.
//  Options  : DIV_PERIOD_CNT_EN - adds period_count[15:0], a count of
//             completed periods since the last start.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = DIV_DEF_PERIOD,
    parameter int DEF_HIGH   = DIV_DEF_HIGH
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             run,
    output logic             clk_out,
    output logic             period_tick,
    output logic             cfg_err,
    output logic             busy
`ifdef DIV_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_count
`endif
);

    div_state_e       state_q;
    div_state_e       state_d;

    logic [CNT_W-1:0] act_period_q;
    logic [CNT_W-1:0] act_period_d;
    logic [CNT_W-1:0] act_high_q;
    logic [CNT_W-1:0] act_high_d;
    logic [CNT_W-1:0] pend_period_q;
    logic [CNT_W-1:0] pend_period_d;
    logic [CNT_W-1:0] pend_high_q;
    logic [CNT_W-1:0] pend_high_d;
    logic             pend_valid_q;
    logic             pend_valid_d;
    logic             cfg_err_q;
    logic             cfg_err_d;

    logic             active;
    logic             active_nxt;
    logic             at_last;
    logic             tick;
    logic             accept;
    logic             cfg_ok;
    logic             apply;

    assign active     = (state_q != ST_IDLE);
    assign active_nxt = (state_d != ST_IDLE);
    assign tick       = active && at_last;

    // The slot is one deep: a held ratio blocks further offers until applied.
    assign cfg_ready  = !pend_valid_q;
    assign accept     = cfg_valid && cfg_ready;
    assign cfg_ok     = cfg_is_valid(CFG_CHK_W'(cfg_period), CFG_CHK_W'(cfg_high));

    // Held ratio takes effect at once when idle, otherwise on the wrap edge
    // that closes the current period. A ratio captured during the tick cycle
    // is not yet in the slot, so it waits for the following boundary.
    assign apply      = pend_valid_q && (!active || tick);

    // Start/stop sequencing. Stopping never cuts a period short: run is
    // only honoured at the boundary, and raising it again before the
    // boundary resumes without a gap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = tick ? ST_IDLE : ST_STOP;
                end
            end
            ST_STOP: begin
                if (run) begin
                    state_d = ST_RUN;
                end else if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake capture, validity screening and pending-to-active transfer.
    // Invalid ratios complete the handshake but never occupy the slot.
    always_comb begin
        act_period_d  = act_period_q;
        act_high_d    = act_high_q;
        pend_period_d = pend_period_q;
        pend_high_d   = pend_high_q;
        pend_valid_d  = pend_valid_q;
        cfg_err_d     = accept && !cfg_ok;

        if (apply) begin
            act_period_d = pend_period_q;
            act_high_d   = pend_high_q;
            pend_valid_d = 1'b0;
        end

        if (accept && cfg_ok) begin
            pend_period_d = cfg_period;
            pend_high_d   = cfg_high;
            pend_valid_d  = 1'b1;
        end
    end

    // Active ratio, pending slot and error pulse registers.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            act_period_q  <= CNT_W'(DEF_PERIOD);
            act_high_q    <= CNT_W'(DEF_HIGH);
            pend_period_q <= '0;
            pend_high_q   <= '0;
            pend_valid_q  <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            act_period_q  <= act_period_d;
            act_high_q    <= act_high_d;
            pend_period_q <= pend_period_d;
            pend_high_q   <= pend_high_d;
            pend_valid_q  <= pend_valid_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    // The tick compare uses the ratio in force now; clk_out pairs with the
    // ratio that will be in force after this edge.
    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk_in     (clk_in),
        .rst        (rst),
        .active     (active),
        .active_nxt (active_nxt),
        .act_period (act_period_q),
        .nxt_high   (act_high_d),
        .at_last    (at_last),
        .clk_out    (clk_out)
    );

    assign period_tick = tick;
    assign cfg_err     = cfg_err_q;
    assign busy        = active;

`ifdef DIV_PERIOD_CNT_EN
    logic [15:0] period_count_q;
    logic [15:0] period_count_d;

    // Completed-period counter: restarts on each start, bumps on every
    // boundary edge, and rolls over naturally at 16 bits.
    always_comb begin
        period_count_d = period_count_q;
        if (!active && active_nxt) begin
            period_count_d = '0;
        end else if (tick) begin
            period_count_d = period_count_q + 16'd1;
        end
    end

    // Completed-period counter register.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            period_count_q <= '0;
        end else begin
            period_count_q <= period_count_d;
        end
    end

    assign period_count = period_count_q;
`endif

endmodule
`default_nettype wire
